// File: rtl/ro_scan_scheduler.sv
// Ring-oscillator scan sequencer: settle, gate, capture, then
// send a 3-byte frame {hdr, cnt_hi, cnt_lo} per enabled channel.
module ro_scan_scheduler #(
  parameter int CW            = 16,
  parameter int SETTLE_CYCLES = 16,
  parameter int GATE_CYCLES   = 10000
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  input  logic          continuous,
  input  logic [3:0]    chan_mask,
  input  logic [CW-1:0] count,
  input  logic          tx_busy,
  output logic [1:0]    osc_sel,
  output logic          osc_en,
  output logic          cnt_clr,
  output logic          cnt_en,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] last_count
);

  localparam int MAXC =
    (GATE_CYCLES > SETTLE_CYCLES) ?
    GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [TW-1:0] SET_LAST =
    TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] GATE_LAST =
    TW'(GATE_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETTLE,
    S_CLEAR,
    S_GATE,
    S_CAPTURE,
    S_TX_ISSUE,
    S_TX_ACK,
    S_TX_WAIT,
    S_NEXT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q;
  logic [1:0]    chan_q, chan_d;
  logic [3:0]    mask_q;
  logic [1:0]    bidx_q;

  logic [1:0] first_start;
  logic [1:0] first_q;
  logic [1:0] nxt_chan;
  logic       nxt_found;
  logic [7:0] frame_byte;

  always_comb begin
    first_start = 2'd0;
    first_q     = 2'd0;
    nxt_chan    = chan_q;
    nxt_found   = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (chan_mask[i]) first_start = 2'(i);
      if (mask_q[i]) first_q = 2'(i);
      if (mask_q[i] && i > int'(chan_q)) begin
        nxt_chan  = 2'(i);
        nxt_found = 1'b1;
      end
    end
  end

  always_comb begin
    unique case (bidx_q)
      2'd0:    frame_byte = {4'hA, 2'b00, chan_q};
      2'd1:    frame_byte = last_count[15:8];
      2'd2:    frame_byte = last_count[7:0];
      default: frame_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    osc_en   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && chan_mask != 4'd0) begin
          state_d = S_SETTLE;
          chan_d  = first_start;
        end
      end
      S_SETTLE: begin
        osc_en = 1'b1;
        if (tmr_q == SET_LAST) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        osc_en  = 1'b1;
        cnt_clr = 1'b1;
        state_d = S_GATE;
      end
      S_GATE: begin
        osc_en = 1'b1;
        cnt_en = 1'b1;
        if (tmr_q == GATE_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: state_d = S_TX_ISSUE;
      S_TX_ISSUE: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          tx_data  = frame_byte;
          state_d  = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        if (tx_busy) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (!tx_busy)
          state_d = (bidx_q == 2'd2) ?
                    S_NEXT : S_TX_ISSUE;
      end
      S_NEXT: begin
        if (nxt_found) begin
          chan_d  = nxt_chan;
          state_d = S_SETTLE;
        end else if (continuous) begin
          chan_d  = first_q;
          state_d = S_SETTLE;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort: nothing new leaves the block this cycle.
    if (!ena) begin
      state_d  = S_IDLE;
      chan_d   = chan_q;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      done     = 1'b0;
    end
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      chan_q     <= 2'd0;
      mask_q     <= 4'd0;
      bidx_q     <= 2'd0;
      last_count <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      tmr_q   <= (state_d != state_q) ?
                 '0 : tmr_q + TW'(1);
      if (state_q == S_IDLE && state_d == S_SETTLE)
        mask_q <= chan_mask;
      if (state_q == S_CAPTURE && ena) begin
        last_count <= count;
        bidx_q     <= 2'd0;
      end else if (state_q == S_TX_WAIT &&
                   state_d == S_TX_ISSUE) begin
        bidx_q <= bidx_q + 2'd1;
      end
    end
  end

  assign osc_sel = chan_q;
  assign busy    = (state_q != S_IDLE);

endmodule
